// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, little-endian byte stream into instruction memory while holding the core in reset
module imem_loader #(
    parameter int WIDTH1   = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      wr,
    output logic [WIDTH1-1:0]         addr,
    output logic [WIDTH1-1:0]         wdata,
    output logic                      core_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [$clog2(MEM_SIZE):0] words_loaded
);
    localparam int WCW = $clog2(MEM_SIZE) + 1;
    localparam logic [31:0] MAXW = 32'(MEM_SIZE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] SETUP  = 3'd4;
    localparam logic [2:0] WRITE  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    logic [2:0]     state;
    logic [15:0]    len;
    logic [1:0]     cnt;
    logic [23:0]    sbuf;
    logic [15:0]    n;
    logic [WCW-1:0] next_wl;

    assign n         = {in_data, len[7:0]};
    assign next_wl   = words_loaded + WCW'(1);
    assign in_ready  = state == LEN_LO || state == LEN_HI || state == DATA;
    assign busy      = in_ready || state == SETUP || state == WRITE;
    assign done      = state == DONE;
    assign error     = state == ERROR;
    assign core_hold = state != DONE;

    // session sequencer: length capture, byte assembly, registered write strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            cnt          <= '0;
            sbuf         <= '0;
            addr         <= '0;
            wdata        <= '0;
            wr           <= 1'b0;
            words_loaded <= '0;
        end else begin
            wr <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state        <= LEN_LO;
                    words_loaded <= '0;
                    cnt          <= '0;
                end
                LEN_LO: if (in_valid) begin
                    len[7:0] <= in_data;
                    state    <= LEN_HI;
                end
                LEN_HI: if (in_valid) begin
                    len[15:8] <= in_data;
                    state     <= n == 16'd0 ? DONE : {16'd0, n} > MAXW ? ERROR : DATA;
                end
                DATA: if (in_valid) begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        wdata <= WIDTH1'({in_data, sbuf});
                        addr  <= WIDTH1'(words_loaded) << 2;
                        state <= SETUP;
                    end else begin
                        sbuf <= {in_data, sbuf[23:8]};
                    end
                end
                SETUP: begin
                    wr    <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    words_loaded <= next_wl;
                    state        <= 32'(next_wl) == 32'(len) ? DONE : DATA;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader against a word-list reference model
module tb_imem_loader;
    localparam int MS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, wr, core_hold, busy, done, error;
    logic [31:0] addr, wdata;
    logic [10:0] words_loaded;

    int checks = 0;
    int errors = 0;
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] wq[$];
    logic        pwr = 1'b0;
    logic [31:0] pa = 32'd0;
    logic [31:0] pd = 32'd0;

    imem_loader #(.WIDTH1(32), .MEM_SIZE(MS)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr(wr), .addr(addr), .wdata(wdata), .core_hold(core_hold),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_core_hold"}, core_hold, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        g = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_session(input int n, input int maxgap);
        int  t;
        logic ok;
        ok = n <= MS;
        if (n >= 1 && ok)
            for (int i = 0; i < n; i++) begin
                ea.push_back(32'(i * 4));
                ed.push_back(wq[i]);
            end
        do_start();
        send_byte(8'(n), maxgap);
        send_byte(8'(n >> 8), maxgap);
        if (n >= 1 && ok)
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++)
                    send_byte(8'(wq[i] >> (8 * b)), maxgap);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!(done || error) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("end_done", done, ok);
        chk("end_error", error, !ok);
        chk("end_core_hold", core_hold, !ok);
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 0);
        chk("end_words", words_loaded, ok ? n : 0);
        chk("end_pending_writes", ea.size(), 0);
        ea.delete();
        ed.delete();
    endtask

    // write monitor: every strobe must match the next expected write and hold addr/wdata around it
    always @(negedge clk) begin
        if (wr) begin
            chk("wr_expected", ea.size() != 0, 1);
            if (ea.size() != 0) begin
                chk("wr_addr", addr, ea.pop_front());
                chk("wr_data", wdata, ed.pop_front());
            end
            chk("wr_in_ready_low", in_ready, 0);
            chk("wr_addr_from_setup", addr, pa);
            chk("wr_data_from_setup", wdata, pd);
        end
        if (pwr) begin
            chk("post_wr_addr", addr, pa);
            chk("post_wr_data", wdata, pd);
        end
        pwr <= wr;
        pa  <= addr;
        pd  <= wdata;
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle("por");
        reset = 1'b0;

        wq = '{32'h0000_0013, 32'h0010_0093};
        run_session(2, 0);

        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        reset = 1'b0;

        run_session(0, 0);
        run_session(1025, 0);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(1, 16));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_session(n, (k % 2) ? 3 : 0);
        end

        wq.delete();
        for (int i = 0; i < MS; i++) wq.push_back(32'(i));
        run_session(MS, 0);

        do_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1 check_idle("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("post_mid_rst");

        wq = '{32'hDEAD_BEEF};
        run_session(1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
